// File: rtl/elevator_car_model.sv
// Behavioural model of an elevator car: motor travel, door mechanism and
// protocol checking. It answers the controller's motor and door commands with
// registered floor, arrival and door-state feedback.
module elevator_car_model #(
    parameter int NUM_FLOORS    = 5,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3,
    parameter int RESET_FLOOR   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  motor_up,
    input  logic                  motor_down,
    input  logic                  door_open_cmd,
    output logic [2:0]            floor,
    output logic [NUM_FLOORS-1:0] floor_onehot,
    output logic                  at_floor,
    output logic                  moving,
    output logic                  door_open,
    output logic                  door_closed,
    output logic                  fault
);

    // One shared down-counter times both floor travel and door motion.
    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0]         TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0]         DOOR_LOAD   = CW'(DOOR_CYCLES - 1);
    localparam logic [CW-1:0]         CNT_ONE     = CW'(1);
    localparam logic [2:0]            TOP_FLOOR   = 3'(NUM_FLOORS - 1);
    localparam logic [2:0]            BOT_FLOOR   = 3'd0;
    localparam logic [2:0]            RST_FLOOR   = 3'(RESET_FLOOR);
    localparam logic [NUM_FLOORS-1:0] ONEHOT_LSB  = NUM_FLOORS'(1);
    localparam logic [NUM_FLOORS-1:0] RST_ONEHOT  = ONEHOT_LSB << RESET_FLOOR;

    localparam logic [2:0] S_STOPPED      = 3'd0;
    localparam logic [2:0] S_MOVING       = 3'd1;
    localparam logic [2:0] S_DOOR_OPENING = 3'd2;
    localparam logic [2:0] S_DOOR_OPEN    = 3'd3;
    localparam logic [2:0] S_DOOR_CLOSING = 3'd4;
    localparam logic [2:0] S_FAULT        = 3'd5;

    logic [2:0]            r_state;
    logic                  r_dir_up;
    logic [CW-1:0]         r_cnt;
    logic [2:0]            r_floor;
    logic [NUM_FLOORS-1:0] r_onehot;
    logic                  r_at_floor;
    logic                  r_moving;
    logic                  r_door_open;
    logic                  r_door_closed;
    logic                  r_fault;

    logic [2:0]            w_nxt_state;
    logic                  w_nxt_dir_up;
    logic [CW-1:0]         w_nxt_cnt;
    logic [2:0]            w_nxt_floor;
    logic [NUM_FLOORS-1:0] w_nxt_onehot;
    logic                  w_nxt_at_floor;
    logic                  w_nxt_moving;
    logic                  w_nxt_door_open;
    logic                  w_nxt_door_closed;
    logic                  w_nxt_fault;

    logic                  w_both_motor;
    logic                  w_motor_door;
    logic                  w_reverse;
    logic                  w_end_stop;
    logic                  w_fault_hit;
    logic [2:0]            w_step_floor;
    logic [NUM_FLOORS-1:0] w_step_onehot;
    logic                  w_more_floors;
    logic                  w_same_cmd;
    logic                  w_cnt_zero;

    // Protocol-violation detection and arrival-floor arithmetic.
    always_comb begin
        w_both_motor  = motor_up & motor_down;
        w_motor_door  = (motor_up | motor_down) & ~r_door_closed;
        w_reverse     = (r_state == S_MOVING) & (r_dir_up ? motor_down : motor_up);
        w_end_stop    = (r_state == S_STOPPED) &
                        ((motor_up & (r_floor == TOP_FLOOR)) |
                         (motor_down & (r_floor == BOT_FLOOR)));
        w_fault_hit   = w_both_motor | w_motor_door | w_reverse | w_end_stop;
        w_step_floor  = r_dir_up ? (r_floor + 3'd1) : (r_floor - 3'd1);
        w_step_onehot = ONEHOT_LSB << w_step_floor;
        w_more_floors = r_dir_up ? (w_step_floor != TOP_FLOOR) : (w_step_floor != BOT_FLOOR);
        w_same_cmd    = r_dir_up ? motor_up : motor_down;
        w_cnt_zero    = (r_cnt == '0);
    end

    // Next-state and next-output decode for the car/door state machine.
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_dir_up      = r_dir_up;
        w_nxt_cnt         = r_cnt;
        w_nxt_floor       = r_floor;
        w_nxt_onehot      = r_onehot;
        w_nxt_at_floor    = r_at_floor;
        w_nxt_moving      = r_moving;
        w_nxt_door_open   = r_door_open;
        w_nxt_door_closed = r_door_closed;
        w_nxt_fault       = r_fault;

        if ((r_state != S_FAULT) && w_fault_hit) begin
            // Freeze position and door where they are; only the motor is cut.
            w_nxt_state  = S_FAULT;
            w_nxt_fault  = 1'b1;
            w_nxt_moving = 1'b0;
        end else begin
            case (r_state)
                S_STOPPED: begin
                    if (motor_up && (r_floor != TOP_FLOOR)) begin
                        w_nxt_state    = S_MOVING;
                        w_nxt_dir_up   = 1'b1;
                        w_nxt_cnt      = TRAVEL_LOAD;
                        w_nxt_moving   = 1'b1;
                        w_nxt_at_floor = 1'b0;
                        w_nxt_onehot   = '0;
                    end else if (motor_down && (r_floor != BOT_FLOOR)) begin
                        w_nxt_state    = S_MOVING;
                        w_nxt_dir_up   = 1'b0;
                        w_nxt_cnt      = TRAVEL_LOAD;
                        w_nxt_moving   = 1'b1;
                        w_nxt_at_floor = 1'b0;
                        w_nxt_onehot   = '0;
                    end else if (door_open_cmd) begin
                        w_nxt_state       = S_DOOR_OPENING;
                        w_nxt_cnt         = DOOR_LOAD;
                        w_nxt_door_closed = 1'b0;
                    end
                end
                S_MOVING: begin
                    if (!w_cnt_zero) begin
                        // Between floors; also clears a pass-through arrival pulse.
                        w_nxt_cnt      = r_cnt - CNT_ONE;
                        w_nxt_at_floor = 1'b0;
                        w_nxt_onehot   = '0;
                    end else begin
                        w_nxt_floor    = w_step_floor;
                        w_nxt_onehot   = w_step_onehot;
                        w_nxt_at_floor = 1'b1;
                        if (w_same_cmd && w_more_floors) begin
                            w_nxt_cnt = TRAVEL_LOAD;
                        end else begin
                            w_nxt_state  = S_STOPPED;
                            w_nxt_moving = 1'b0;
                        end
                    end
                end
                S_DOOR_OPENING: begin
                    if (!w_cnt_zero) begin
                        w_nxt_cnt = r_cnt - CNT_ONE;
                    end else begin
                        w_nxt_state     = S_DOOR_OPEN;
                        w_nxt_door_open = 1'b1;
                    end
                end
                S_DOOR_OPEN: begin
                    if (!door_open_cmd) begin
                        w_nxt_state     = S_DOOR_CLOSING;
                        w_nxt_cnt       = DOOR_LOAD;
                        w_nxt_door_open = 1'b0;
                    end
                end
                S_DOOR_CLOSING: begin
                    if (door_open_cmd) begin
                        w_nxt_state = S_DOOR_OPENING;
                        w_nxt_cnt   = DOOR_LOAD;
                    end else if (!w_cnt_zero) begin
                        w_nxt_cnt = r_cnt - CNT_ONE;
                    end else begin
                        w_nxt_state       = S_STOPPED;
                        w_nxt_door_closed = 1'b1;
                    end
                end
                default: begin
                    // Fault is sticky until reset.
                end
            endcase
        end
    end

    // State and registered outputs, asynchronously reset to parked-at-RESET_FLOOR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_STOPPED;
            r_dir_up      <= 1'b1;
            r_cnt         <= '0;
            r_floor       <= RST_FLOOR;
            r_onehot      <= RST_ONEHOT;
            r_at_floor    <= 1'b1;
            r_moving      <= 1'b0;
            r_door_open   <= 1'b0;
            r_door_closed <= 1'b1;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_dir_up      <= w_nxt_dir_up;
            r_cnt         <= w_nxt_cnt;
            r_floor       <= w_nxt_floor;
            r_onehot      <= w_nxt_onehot;
            r_at_floor    <= w_nxt_at_floor;
            r_moving      <= w_nxt_moving;
            r_door_open   <= w_nxt_door_open;
            r_door_closed <= w_nxt_door_closed;
            r_fault       <= w_nxt_fault;
        end
    end

    assign floor        = r_floor;
    assign floor_onehot = r_onehot;
    assign at_floor     = r_at_floor;
    assign moving       = r_moving;
    assign door_open    = r_door_open;
    assign door_closed  = r_door_closed;
    assign fault        = r_fault;

endmodule

// File: tb/tb_elevator_car_model.sv
// Scoreboard bench for elevator_car_model: directed scenarios plus random
// command episodes, checked against a position-in-ticks reference model.
module tb_elevator_car_model;

    localparam int N  = 5;
    localparam int T  = 4;
    localparam int D  = 3;
    localparam int RF = 0;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         motor_up = 1'b0;
    logic         motor_down = 1'b0;
    logic         door_open_cmd = 1'b0;
    logic [2:0]   floor;
    logic [N-1:0] floor_onehot;
    logic         at_floor, moving, door_open, door_closed, fault;

    always #5 clk = ~clk;

    elevator_car_model #(
        .NUM_FLOORS   (N),
        .TRAVEL_CYCLES(T),
        .DOOR_CYCLES  (D),
        .RESET_FLOOR  (RF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .motor_up     (motor_up),
        .motor_down   (motor_down),
        .door_open_cmd(door_open_cmd),
        .floor        (floor),
        .floor_onehot (floor_onehot),
        .at_floor     (at_floor),
        .moving       (moving),
        .door_open    (door_open),
        .door_closed  (door_closed),
        .fault        (fault)
    );

    typedef struct packed {
        logic [2:0]   fl;
        logic [N-1:0] oh;
        logic         at;
        logic         mv;
        logic         op;
        logic         cl;
        logic         ft;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: car position tracked in travel ticks (floor*T).
    localparam int M_IDLE = 0, M_TRAVEL = 1, M_OPENING = 2, M_HOLD = 3, M_CLOSING = 4, M_FAULT = 5;
    int m_mode, m_pos, m_dir, m_prog, m_floor;
    bit m_at, m_mv, m_op, m_cl, m_ft;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_pos = RF * T; m_dir = 1; m_prog = 0; m_floor = RF;
        m_at = 1; m_mv = 0; m_op = 0; m_cl = 1; m_ft = 0;
    endtask

    task automatic model_step(input bit up, input bit dn, input bit cmd);
        bit bad;
        bit keep_going;
        if (m_mode == M_FAULT) return;
        bad = (up && dn) || ((up || dn) && !m_cl) ||
              (m_mode == M_TRAVEL && ((m_dir > 0 && dn) || (m_dir < 0 && up))) ||
              (m_mode == M_IDLE && ((up && m_floor == N - 1) || (dn && m_floor == 0)));
        if (bad) begin
            m_mode = M_FAULT; m_ft = 1; m_mv = 0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (up || dn) begin
                    m_dir = up ? 1 : -1; m_mode = M_TRAVEL; m_mv = 1; m_at = 0;
                end else if (cmd) begin
                    m_mode = M_OPENING; m_prog = 0; m_cl = 0;
                end
            end
            M_TRAVEL: begin
                m_pos   = m_pos + m_dir;
                m_floor = (m_dir > 0) ? (m_pos / T) : ((m_pos + T - 1) / T);
                m_at    = (m_pos % T) == 0;
                if (m_at) begin
                    keep_going = ((m_dir > 0) ? up : dn) &&
                                 (m_floor + m_dir >= 0) && (m_floor + m_dir <= N - 1);
                    if (!keep_going) begin
                        m_mode = M_IDLE; m_mv = 0;
                    end
                end
            end
            M_OPENING: begin
                m_prog++;
                if (m_prog == D) begin m_op = 1; m_mode = M_HOLD; end
            end
            M_HOLD: begin
                if (!cmd) begin m_op = 0; m_mode = M_CLOSING; m_prog = 0; end
            end
            M_CLOSING: begin
                if (cmd) begin
                    m_mode = M_OPENING; m_prog = 0;
                end else begin
                    m_prog++;
                    if (m_prog == D) begin m_cl = 1; m_mode = M_IDLE; end
                end
            end
            default: ;
        endcase
    endtask

    function automatic exp_t cur_exp();
        exp_t x;
        x.fl = 3'(m_floor);
        x.oh = m_at ? N'(1 << m_floor) : '0;
        x.at = m_at; x.mv = m_mv; x.op = m_op; x.cl = m_cl; x.ft = m_ft;
        return x;
    endfunction

    // Apply one cycle of commands and queue the expected post-edge outputs.
    task automatic drive(input bit up, input bit dn, input bit cmd);
        @(negedge clk);
        motor_up = up; motor_down = dn; door_open_cmd = cmd;
        model_step(up, dn, cmd);
        q.push_back(cur_exp());
    endtask

    // Asynchronous reset between clock edges; outputs checked before any edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1; motor_up = 0; motor_down = 0; door_open_cmd = 0;
        #1;
        chk("rst_floor",  32'(floor),        32'(RF));
        chk("rst_onehot", 32'(floor_onehot), 32'(1 << RF));
        chk("rst_at",     32'(at_floor),     32'd1);
        chk("rst_moving", 32'(moving),       32'd0);
        chk("rst_open",   32'(door_open),    32'd0);
        chk("rst_closed", 32'(door_closed),  32'd1);
        chk("rst_fault",  32'(fault),        32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic goto_floor(input int target);
        for (int k = 0; k < N && m_floor != target; k++) begin
            if (target > m_floor) drive(1, 0, 0); else drive(0, 1, 0);
            repeat (T) drive(0, 0, 0);
        end
    endtask

    task automatic rand_cycle();
        int r;
        bit u, d, c;
        r = $urandom_range(0, 99);
        u = 0; d = 0; c = 0;
        case (m_mode)
            M_IDLE: begin
                if (r < 40)      begin if (m_floor < N - 1) u = 1; else d = 1; end
                else if (r < 65) begin if (m_floor > 0) d = 1; else u = 1; end
                else if (r < 88) c = 1;
                else if (r < 91) begin u = 1; d = 1; end
                else if (r < 93) begin if (m_floor == 0) d = 1; else u = 1; end
                else if (r < 95) begin u = 1; c = 1; end
            end
            M_TRAVEL: begin
                if (r < 65) begin if (m_dir > 0) u = 1; else d = 1; end
                else if (r >= 97) begin if (m_dir > 0) d = 1; else u = 1; end
            end
            M_OPENING, M_HOLD, M_CLOSING: begin
                c = (r < 60);
                u = (r >= 98);
            end
            default: begin
                u = (r % 3 == 0); d = (r % 5 == 0); c = (r % 2 == 0);
            end
        endcase
        drive(u, d, c);
    endtask

    // Monitor: every queued expectation is compared just after its edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("floor",       32'(floor),        32'(e.fl));
                chk("floor_onehot", 32'(floor_onehot), 32'(e.oh));
                chk("at_floor",    32'(at_floor),     32'(e.at));
                chk("moving",      32'(moving),       32'(e.mv));
                chk("door_open",   32'(door_open),    32'(e.op));
                chk("door_closed", 32'(door_closed),  32'(e.cl));
                chk("fault",       32'(fault),        32'(e.ft));
                chk("door_excl",   32'(door_open & door_closed), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // Single-cycle up pulse: one floor of travel, then stop.
        drive(1, 0, 0);
        repeat (6) drive(0, 0, 0);
        do_reset();

        // Held up from floor 0 passes floors 1..3 and stops at the top.
        for (int i = 0; i < 40; i++) begin
            drive(1, 0, 0);
            if (m_at && m_floor == N - 1) break;
        end
        repeat (2) drive(0, 0, 0);
        do_reset();

        // Door cycle at floor 2.
        goto_floor(2);
        repeat (6) drive(0, 0, 1);
        repeat (5) drive(0, 0, 0);

        // Reopen one cycle into closing.
        repeat (5) drive(0, 0, 1);
        repeat (2) drive(0, 0, 0);
        repeat (5) drive(0, 0, 1);
        repeat (5) drive(0, 0, 0);

        // Both motors together: sticky fault, then reset mid-fault.
        drive(1, 1, 0);
        repeat (3) drive(0, 0, 0);
        do_reset();

        // Motor command while door is open.
        repeat (5) drive(0, 0, 1);
        drive(1, 0, 1);
        repeat (3) drive(0, 0, 0);
        do_reset();

        // Up command at the top floor.
        goto_floor(N - 1);
        drive(0, 0, 0);
        drive(1, 0, 0);
        repeat (3) drive(0, 0, 0);

        // Down travel with a pass-through, then up command mid-travel.
        do_reset();
        goto_floor(3);
        for (int i = 0; i < 2 * T; i++) drive(0, 1, 0);
        drive(0, 0, 0);
        drive(0, 1, 0);
        drive(1, 0, 0);
        repeat (2) drive(0, 0, 0);

        // Randomised episodes.
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int c = 0; c < 80; c++) rand_cycle();
        end

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
